// File: rtl/param_delay_box.sv
// Delay line DEPTH stages deep that advances once every STEP_CYCLES enabled clocks.
// Output is either the last stage (DELAY) or its per-bit rising edges against the previous output sample (EDGE).
module param_delay_box #(
  parameter int         WIDTH       = 8,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] RESET_VALUE = 8'hA5,
  parameter string      MODE        = "DELAY",
  parameter real        STEP_RATIO  = 1.0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             step_o,
  output logic             valid_o
);

  // Zero-extend or truncate the 8-bit reset value to the data width.
  function automatic logic [WIDTH-1:0] rst_word_f(input logic [7:0] rv);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int b = 0; b < WIDTH && b < 8; b++) begin
      w[b] = rv[b];
    end
    return w;
  endfunction

  // Adding 0.5 and truncating gives round-half-away-from-zero for ratios of 1.5 and above.
  // Every smaller ratio clamps to one clock per step.
  localparam int STEP_CYCLES = (STEP_RATIO + 0.5 < 2.0) ? 1 : $rtoi(STEP_RATIO + 0.5);
  localparam int CNT_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int FILL_W      = $clog2(DEPTH + 1);
  localparam bit IS_EDGE     = (MODE == "EDGE");

  localparam logic [WIDTH-1:0]  RST_W     = rst_word_f(RESET_VALUE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  stage_r [DEPTH];
  logic [WIDTH-1:0]  hist_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [FILL_W-1:0] fill_r;
  logic              step_s;

  // Reset is folded in so step_o reads low the moment rst_n falls, with no clock edge needed.
  assign step_s = rst_n & en & ~flush & (cnt_r == CNT_LAST);

  // Prescaler counter and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      fill_r <= '0;
    end else if (flush) begin
      cnt_r  <= '0;
      fill_r <= '0;
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (step_s && (fill_r != FILL_FULL)) begin
        fill_r <= fill_r + FILL_W'(1);
      end
    end
  end

  // Shift register plus the history copy of the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k] <= RST_W;
      end
      hist_r <= RST_W;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k] <= RST_W;
      end
      hist_r <= RST_W;
    end else if (step_s) begin
      stage_r[0] <= I;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
      hist_r <= stage_r[DEPTH-1];
    end
  end

  // Output mode is fixed at elaboration.
  always_comb begin
    O = stage_r[DEPTH-1];
    if (IS_EDGE) begin
      O = stage_r[DEPTH-1] & ~hist_r;
    end else begin
      O = stage_r[DEPTH-1];
    end
  end

  assign step_o  = step_s;
  assign valid_o = (fill_r == FILL_FULL);

endmodule

// File: tb/tb_param_delay_box.sv
// Scoreboarded bench for param_delay_box: stimulus pushes hand-computed {valid,O} per step,
// per-instance monitors pop and compare on the negedge after each step.
module tb_param_delay_box;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst_n, rst0_n, rst2_n;
  logic        en0, fl0, en2, en3;
  logic [7:0]  i0, i3;
  logic        lo = 1'b0;
  logic [7:0]  zero8 = 8'h00;
  logic [11:0] zero12 = 12'h000;

  logic [7:0]  o0, o1, o2, o3, o4;
  logic [11:0] o1w;
  logic        st0, st1, st1w, st2, st3, st4;
  logic        v0, v1, v1w, v2, v3, v4;

  param_delay_box u0 (.clk(clk), .rst_n(rst0_n), .en(en0), .flush(fl0), .I(i0),
                      .O(o0), .step_o(st0), .valid_o(v0));
  param_delay_box #(.RESET_VALUE(8'(65535))) u1 (.clk(clk), .rst_n(rst_n), .en(lo), .flush(lo),
                      .I(zero8), .O(o1), .step_o(st1), .valid_o(v1));
  param_delay_box #(.WIDTH(12), .RESET_VALUE(8'(65535))) u1w (.clk(clk), .rst_n(rst_n), .en(lo),
                      .flush(lo), .I(zero12), .O(o1w), .step_o(st1w), .valid_o(v1w));
  param_delay_box #(.STEP_RATIO(2.5)) u2 (.clk(clk), .rst_n(rst2_n), .en(en2), .flush(lo),
                      .I(zero8), .O(o2), .step_o(st2), .valid_o(v2));
  param_delay_box #(.MODE("EDGE"), .DEPTH(2)) u3 (.clk(clk), .rst_n(rst_n), .en(en3), .flush(lo),
                      .I(i3), .O(o3), .step_o(st3), .valid_o(v3));
  param_delay_box #(.MODE("XEDGE")) u4 (.clk(clk), .rst_n(rst_n), .en(lo), .flush(lo),
                      .I(zero8), .O(o4), .step_o(st4), .valid_o(v4));

  logic [8:0] q0[$];
  logic [8:0] q3[$];
  logic       prev0 = 1'b0;
  logic       prev3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input logic [7:0] din, input logic [8:0] exp);
    en0 = 1'b1;
    i0  = din;
    q0.push_back(exp);
    tick();
  endtask

  task automatic step3(input logic [7:0] din, input logic [8:0] exp);
    en3 = 1'b1;
    i3  = din;
    q3.push_back(exp);
    tick();
  endtask

  // Monitor for u0: a step seen at one negedge is checked at the next.
  always @(negedge clk) begin
    if (prev0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb0_unexpected_step: got step with empty queue, required none at %0t", $time);
      end else begin
        check("sb0", {23'd0, v0, o0}, {23'd0, q0.pop_front()});
      end
    end
    prev0 = st0;
  end

  // Monitor for u3 (EDGE mode).
  always @(negedge clk) begin
    if (prev3) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb3_unexpected_step: got step with empty queue, required none at %0t", $time);
      end else begin
        check("sb3", {23'd0, v3, o3}, {23'd0, q3.pop_front()});
      end
    end
    prev3 = st3;
  end

  initial begin
    rst_n = 1'b0; rst0_n = 1'b0; rst2_n = 1'b0;
    en0 = 1'b0; fl0 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    i0 = 8'h00; i3 = 8'h00;
    tick();
    en0 = 1'b1;
    #1;
    check("rst_step_gated", {31'd0, st0}, 32'd0);
    check("rst_o0", {24'd0, o0}, 32'h0A5);
    check("rst_v0", {31'd0, v0}, 32'd0);
    check("rst_o1_trunc", {24'd0, o1}, 32'h0FF);
    check("rst_o1w_w12", {20'd0, o1w}, 32'h0FF);
    check("rst_o3_edge", {24'd0, o3}, 32'h000);
    check("rst_o4_badmode", {24'd0, o4}, 32'h0A5);
    check("rst_o2", {24'd0, o2}, 32'h0A5);
    check("rst_idle_flags", {26'd0, st1, v1, st1w, v1w, st4, v4}, 32'd0);
    en0 = 1'b0;
    tick();
    rst_n = 1'b1; rst0_n = 1'b1; rst2_n = 1'b1;
    tick();
    check("idle_o0", {23'd0, v0, o0}, 32'h0A5);

    // Fill and stream through the default instance
    step0(8'h01, 9'h0A5);
    step0(8'h02, 9'h0A5);
    step0(8'h03, 9'h0A5);
    step0(8'h04, 9'h101);
    step0(8'h05, 9'h102);
    step0(8'hC3, 9'h103);
    en0 = 1'b0;
    tick();
    tick();
    check("en_low_hold", {23'd0, v0, o0}, 32'h103);
    step0(8'h3C, 9'h104);

    // Flush with a coincident step
    en0 = 1'b1;
    fl0 = 1'b1;
    #1;
    check("flush_gates_step", {31'd0, st0}, 32'd0);
    tick();
    en0 = 1'b0;
    fl0 = 1'b0;
    #1;
    check("post_flush", {22'd0, st0, v0, o0}, 32'h0A5);
    step0(8'h11, 9'h0A5);
    step0(8'h22, 9'h0A5);
    step0(8'h33, 9'h0A5);
    step0(8'h44, 9'h111);
    step0(8'h55, 9'h122);
    en0 = 1'b0;
    tick();

    // Asynchronous reset between edges with en held high
    en0 = 1'b1;
    rst0_n = 1'b0;
    #1;
    check("async_rst", {22'd0, st0, v0, o0}, 32'h0A5);
    tick();
    #1;
    rst0_n = 1'b1;
    i0 = 8'h66;
    q0.push_back(9'h0A5);
    tick();
    step0(8'h77, 9'h0A5);
    step0(8'h88, 9'h0A5);
    step0(8'h99, 9'h166);
    en0 = 1'b0;
    tick();

    // Prescaler with STEP_CYCLES = 3
    en2 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("presc_run", {31'd0, st2}, (c % 3 == 2) ? 32'd1 : 32'd0);
      tick();
    end
    en2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("presc_hold", {31'd0, st2}, 32'd0);
      tick();
    end
    en2 = 1'b1;
    #1;
    check("presc_resume0", {31'd0, st2}, 32'd0);
    tick();
    check("presc_resume1", {31'd0, st2}, 32'd1);
    tick();
    check("presc_pre_full", {23'd0, v2, o2}, 32'h0A5);
    tick();
    tick();
    tick();
    check("presc_full", {23'd0, v2, o2}, 32'h100);

    // Reset mid-stream on the prescaled instance
    rst2_n = 1'b0;
    #1;
    check("rst2_async", {22'd0, st2, v2, o2}, 32'h0A5);
    tick();
    #1;
    rst2_n = 1'b1;
    #1;
    check("rst2_rel_c0", {31'd0, st2}, 32'd0);
    tick();
    check("rst2_rel_c1", {31'd0, st2}, 32'd0);
    tick();
    check("rst2_rel_c2", {31'd0, st2}, 32'd1);
    en2 = 1'b0;

    // EDGE mode, DEPTH 2
    step3(8'h00, 9'h000);
    step3(8'h0F, 9'h100);
    step3(8'h0F, 9'h10F);
    step3(8'hFF, 9'h100);
    step3(8'hFF, 9'h1F0);
    step3(8'hFF, 9'h100);
    en3 = 1'b0;
    tick();
    tick();

    check("q0_drained", q0.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
